axil_bias_config_master: RTL and testbench

- AXI4-Lite master that programs the layer register block after a single `start` pulse.
- Sequence: writes NUM_BIAS bias words fetched from a local bias table, then writes the control word, then polls the status register until a done bit sets or a timeout expires.
- Sits between the bias/weight loader (table source) and the register block's AXI4-Lite slave; replaces software-driven configuration for standalone inference runs.

---
 rtl/axil_bias_config_master.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axil_bias_config_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_bias_config_master.sv
// axil_bias_config_master
// AXI4-Lite master that programs a layer register block after one start pulse:
// it writes NUM_BIAS bias words taken from a local table, writes the control
// word, then polls the status register until a done bit appears or the poll
// budget runs out.
//
// Optional feature: define AXIL_CFG_READBACK_EN to read back every bias and
// control register after its successful write and compare it against the
// value that was written.
module axil_bias_config_master #(
  parameter int NUM_BIAS     = 18,
  parameter int ADDR_WIDTH   = 7,
  parameter int CTRL_ADDR    = 72,
  parameter int STATUS_ADDR  = 76,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,

  input  logic                  start,
  input  logic [31:0]           ctrl_word,
  input  logic [31:0]           status_mask,

  output logic [4:0]            tbl_addr,
  input  logic [31:0]           tbl_data,

  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,

  output logic [31:0]           m_axil_wdata,
  output logic [3:0]            m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,

  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,

  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,

  input  logic [31:0]           m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int         PCNT_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [4:0] LAST_K = 5'(NUM_BIAS - 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BRESP   = 2'd1;
  localparam logic [1:0] ERR_RRESP   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WADDR_DATA,
    WRESP,
    CTRL,
    POLL_AR,
    POLL_R,
`ifdef AXIL_CFG_READBACK_EN
    RB_AR,
    RB_R,
`endif
    FINISH
  } state_t;

  state_t              state;
  logic [4:0]          k;
  logic [PCNT_W-1:0]   poll_cnt;
  logic                fetch_wait;
  logic                ctrl_phase;
  logic [31:0]         ctrl_q;
  logic [31:0]         mask_q;

  // SLVERR (2'b10) and DECERR (2'b11) both count as a failed response
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  // Protection bits and byte strobes never change: unprivileged, secure, data
  // accesses with all four byte lanes written.
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wstrb  = 4'hF;

  // Configuration sequencer: owns every handshake and all status outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= IDLE;
      k              <= '0;
      poll_cnt       <= '0;
      fetch_wait     <= 1'b0;
      ctrl_phase     <= 1'b0;
      ctrl_q         <= '0;
      mask_q         <= '0;
      tbl_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= ERR_NONE;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            ctrl_q     <= ctrl_word;
            mask_q     <= status_mask;
            k          <= '0;
            tbl_addr   <= '0;
            poll_cnt   <= '0;
            fetch_wait <= 1'b0;
            ctrl_phase <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end

        // tbl_addr is already k on entry; the table answers one cycle later
        FETCH: begin
          if (!fetch_wait) begin
            fetch_wait <= 1'b1;
          end else begin
            m_axil_wdata   <= tbl_data;
            m_axil_awaddr  <= ADDR_WIDTH'({k, 2'b00});
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid  <= 1'b1;
            state          <= WADDR_DATA;
          end
        end

        // AW and W retire independently; move on once both have been taken
        WADDR_DATA: begin
          if (m_axil_awvalid && m_axil_awready) begin
            m_axil_awvalid <= 1'b0;
          end
          if (m_axil_wvalid && m_axil_wready) begin
            m_axil_wvalid <= 1'b0;
          end
          if ((!m_axil_awvalid || m_axil_awready) &&
              (!m_axil_wvalid  || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            state         <= WRESP;
          end
        end

        WRESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            if (resp_is_err(m_axil_bresp)) begin
              error    <= 1'b1;
              err_code <= ERR_BRESP;
              state    <= FINISH;
            end else begin
`ifdef AXIL_CFG_READBACK_EN
              m_axil_araddr  <= m_axil_awaddr;
              m_axil_arvalid <= 1'b1;
              state          <= RB_AR;
`else
              if (ctrl_phase) begin
                state <= POLL_AR;
              end else if (k == LAST_K) begin
                state <= CTRL;
              end else begin
                k          <= k + 5'd1;
                tbl_addr   <= k + 5'd1;
                fetch_wait <= 1'b0;
                state      <= FETCH;
              end
`endif
            end
          end
        end

        CTRL: begin
          m_axil_awaddr  <= ADDR_WIDTH'(CTRL_ADDR);
          m_axil_wdata   <= ctrl_q;
          m_axil_awvalid <= 1'b1;
          m_axil_wvalid  <= 1'b1;
          ctrl_phase     <= 1'b1;
          state          <= WADDR_DATA;
        end

`ifdef AXIL_CFG_READBACK_EN
        RB_AR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= RB_R;
          end
        end

        // wdata still holds the value just written, so it is the reference
        RB_R: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            if (resp_is_err(m_axil_rresp) || (m_axil_rdata != m_axil_wdata)) begin
              error    <= 1'b1;
              err_code <= ERR_RRESP;
              state    <= FINISH;
            end else if (ctrl_phase) begin
              state <= POLL_AR;
            end else if (k == LAST_K) begin
              state <= CTRL;
            end else begin
              k          <= k + 5'd1;
              tbl_addr   <= k + 5'd1;
              fetch_wait <= 1'b0;
              state      <= FETCH;
            end
          end
        end
`endif

        // arvalid rises one cycle after entry, which leaves an idle cycle
        // between the previous status read and the next one
        POLL_AR: begin
          if (!m_axil_arvalid) begin
            m_axil_araddr  <= ADDR_WIDTH'(STATUS_ADDR);
            m_axil_arvalid <= 1'b1;
          end else if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= POLL_R;
          end
        end

        POLL_R: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            if (resp_is_err(m_axil_rresp)) begin
              error    <= 1'b1;
              err_code <= ERR_RRESP;
              state    <= FINISH;
            end else if ((m_axil_rdata & mask_q) != 32'd0) begin
              state <= FINISH;
            end else if (poll_cnt == PCNT_W'(POLL_TIMEOUT - 1)) begin
              poll_cnt <= poll_cnt + PCNT_W'(1);
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
              state    <= FINISH;
            end else begin
              poll_cnt <= poll_cnt + PCNT_W'(1);
              state    <= POLL_AR;
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          done  <= !error;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bias_config_master.sv
// Testbench for axil_bias_config_master: reactive AXI4-Lite slave and bias
// table model, scoreboard of expected bus transactions, end-of-run status.
`timescale 1ns/1ps
module tb_axil_bias_config_master;

  localparam int         NB     = 18;
  localparam int         TO     = 8;
  localparam logic [6:0] CTRL_A = 7'd72;
  localparam logic [6:0] STAT_A = 7'd76;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [31:0] ctrl_word;
  logic [31:0] status_mask;
  logic [4:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [6:0]  m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid, m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid, m_axil_bready;
  logic [6:0]  m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid, m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid, m_axil_rready;

  always #5 aclk = ~aclk;

  axil_bias_config_master #(
    .NUM_BIAS(NB), .ADDR_WIDTH(7), .CTRL_ADDR(72), .STATUS_ADDR(76), .POLL_TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .ctrl_word(ctrl_word),
    .status_mask(status_mask), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  typedef struct {
    bit          rd;
    logic [6:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          exp_code;
  int          exp_done;

  // slave / table configuration
  logic [31:0] tbl  [0:31];
  logic [31:0] regs [0:31];
  int          aw_delay, w_delay, ar_delay;
  int          berr_addr;
  int          set_at;
  int          status_reads;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_txn(input bit rd, input logic [6:0] addr, input logic [31:0] data);
    txn_t t;
    t.rd = rd; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  // Reference model: the bus transactions the sequence must produce, in order
  task automatic build_expected(input int bad_idx, input int sa);
    exp_q.delete();
    exp_code = 0;
    exp_done = 1;
    for (int kk = 0; kk < NB; kk++) begin
      push_txn(1'b0, 7'(4 * kk), tbl[kk]);
      if (bad_idx == kk) begin exp_code = 1; exp_done = 0; return; end
`ifdef AXIL_CFG_READBACK_EN
      push_txn(1'b1, 7'(4 * kk), 32'd0);
`endif
    end
    push_txn(1'b0, CTRL_A, ctrl_word);
    if (bad_idx == NB) begin exp_code = 1; exp_done = 0; return; end
`ifdef AXIL_CFG_READBACK_EN
    push_txn(1'b1, CTRL_A, 32'd0);
`endif
    for (int i = 1; i <= TO; i++) begin
      push_txn(1'b1, STAT_A, 32'd0);
      if (sa != 0 && i >= sa) return;
    end
    exp_code = 3;
    exp_done = 0;
  endtask

  task automatic setup(input bit rnd, input int bad_idx, input int sa,
                       input int awd, input int wd, input int ard);
    for (int kk = 0; kk < 32; kk++) tbl[kk] = rnd ? $urandom : 32'h0678 + kk;
    ctrl_word   = rnd ? $urandom : 32'h0678;
    status_mask = rnd ? (32'd1 << $urandom_range(0, 31)) : 32'd1;
    aw_delay = awd; w_delay = wd; ar_delay = ard;
    berr_addr = (bad_idx < 0) ? -1 : ((bad_idx == NB) ? 72 : 4 * bad_idx);
    set_at = sa;
    status_reads = 0;
    build_expected(bad_idx, sa);
  endtask

  task automatic run_seq(input string tag, input int extra_start);
    int cyc;
    done_cnt = 0;
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 4000) begin
      @(negedge aclk);
      cyc++;
      start = (extra_start != 0 && cyc == extra_start);
    end
    start = 1'b0;
    chk({tag, "_finish_in_time"}, {31'd0, (cyc < 4000)}, 32'd1);
    repeat (20) @(negedge aclk);
    chk({tag, "_done_pulses"}, done_cnt, exp_done);
    chk({tag, "_error"}, {31'd0, error}, {31'd0, (exp_code != 0)});
    chk({tag, "_err_code"}, {30'd0, err_code}, 32'(exp_code));
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_txns_left"}, exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    chk({tag, "_valids"}, {27'd0, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                            m_axil_arvalid, m_axil_rready}, 32'd0);
    chk({tag, "_tbl_addr"}, {27'd0, tbl_addr}, 32'd0);
    chk({tag, "_awaddr"}, {25'd0, m_axil_awaddr}, 32'd0);
    chk({tag, "_wdata"}, m_axil_wdata, 32'd0);
  endtask

  // Slave + bias table: reacts 1 ns after each rising edge
  initial begin
    bit          aw_got, w_got, ar_got, b_seen, r_seen, hit;
    int          aw_wait, w_wait, ar_wait;
    logic [6:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    aw_got = 0; w_got = 0; ar_got = 0; b_seen = 0; r_seen = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
    m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rdata = 0; m_axil_rresp = 0;
    tbl_data = '0;
    forever begin
      @(posedge aclk); #1;
      tbl_data = tbl[tbl_addr];
      if (areset) begin
        aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
        m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rdata = 0; m_axil_rresp = 0;
        continue;
      end
      if (m_axil_awready) begin m_axil_awready = 0; aw_got = 1; end
      else if (m_axil_awvalid && !aw_got) begin
        if (aw_wait >= aw_delay) begin m_axil_awready = 1; s_awaddr = m_axil_awaddr; end
        else aw_wait++;
      end
      if (m_axil_wready) begin m_axil_wready = 0; w_got = 1; end
      else if (m_axil_wvalid && !w_got) begin
        if (w_wait >= w_delay) begin m_axil_wready = 1; s_wdata = m_axil_wdata; end
        else w_wait++;
      end
      if (m_axil_bvalid) begin
        if (b_seen) begin m_axil_bvalid = 0; m_axil_bresp = 0; end
        else b_seen = m_axil_bready;
      end else if (aw_got && w_got) begin
        regs[s_awaddr[6:2]] = s_wdata;
        m_axil_bresp  = (int'(s_awaddr) == berr_addr) ? 2'b10 : 2'b00;
        m_axil_bvalid = 1;
        b_seen = m_axil_bready;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
      end
      if (m_axil_arready) begin m_axil_arready = 0; ar_got = 1; end
      else if (m_axil_arvalid && !ar_got) begin
        if (ar_wait >= ar_delay) begin m_axil_arready = 1; s_araddr = m_axil_araddr; end
        else ar_wait++;
      end
      if (m_axil_rvalid) begin
        if (r_seen) begin m_axil_rvalid = 0; m_axil_rdata = 0; end
        else r_seen = m_axil_rready;
      end else if (ar_got) begin
        ar_got = 0; ar_wait = 0;
        if (s_araddr == STAT_A) begin
          status_reads++;
          hit = (set_at != 0) && (status_reads >= set_at);
          m_axil_rdata = ($urandom & ~status_mask) |
                         (hit ? (status_mask & (~status_mask + 32'd1)) : 32'd0);
        end else begin
          m_axil_rdata = regs[s_araddr[6:2]];
        end
        m_axil_rresp = 2'b00;
        m_axil_rvalid = 1;
        r_seen = m_axil_rready;
      end
    end
  end

  // Monitor: each handshake seen on the bus is matched against the scoreboard
  initial begin
    bit          aw_ok, w_ok, aw_hs_prev, w_hs_prev;
    logic [6:0]  m_aw;
    logic [31:0] m_w;
    txn_t        t;
    aw_ok = 0; w_ok = 0; aw_hs_prev = 0; w_hs_prev = 0; m_aw = '0; m_w = '0;
    forever begin
      @(negedge aclk);
      if (done) done_cnt++;
      if (areset) begin
        aw_ok = 0; w_ok = 0; aw_hs_prev = 0; w_hs_prev = 0;
        continue;
      end
      if (aw_hs_prev) chk("awvalid_drop", {31'd0, m_axil_awvalid}, 32'd0);
      if (w_hs_prev)  chk("wvalid_drop", {31'd0, m_axil_wvalid}, 32'd0);
      aw_hs_prev = m_axil_awvalid && m_axil_awready;
      w_hs_prev  = m_axil_wvalid && m_axil_wready;
      if (aw_hs_prev) begin
        m_aw = m_axil_awaddr; aw_ok = 1;
        chk("awprot", {29'd0, m_axil_awprot}, 32'd0);
      end
      if (w_hs_prev) begin
        m_w = m_axil_wdata; w_ok = 1;
        chk("wstrb", {28'd0, m_axil_wstrb}, 32'hF);
      end
      if (aw_ok && w_ok) begin
        aw_ok = 0; w_ok = 0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected none", m_aw, m_w);
        end else begin
          t = exp_q.pop_front();
          chk("txn_is_write", {31'd0, t.rd}, 32'd0);
          chk("write_addr", {25'd0, m_aw}, {25'd0, t.addr});
          chk("write_data", m_w, t.data);
        end
      end
      if (m_axil_arvalid && m_axil_arready) begin
        chk("arprot", {29'd0, m_axil_arprot}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got addr %h expected none", m_axil_araddr);
        end else begin
          t = exp_q.pop_front();
          chk("txn_is_read", {31'd0, t.rd}, 32'd1);
          chk("read_addr", {25'd0, m_axil_araddr}, {25'd0, t.addr});
        end
      end
    end
  end

  // Stimulus
  initial begin
    int cyc;
    areset = 1'b1; start = 1'b0; ctrl_word = '0; status_mask = 32'd1;
    aw_delay = 0; w_delay = 0; ar_delay = 0; berr_addr = -1; set_at = 1; status_reads = 0;
    for (int kk = 0; kk < 32; kk++) begin tbl[kk] = '0; regs[kk] = '0; end
    repeat (3) @(negedge aclk);
    chk_reset_outputs("reset");
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    setup(1'b0, -1, 1, 0, 0, 0);
    run_seq("nominal", 0);

    setup(1'b1, -1, 1, 3, 0, 0);
    run_seq("aw_stall", 0);

    setup(1'b1, 5, 1, 0, 0, 0);
    run_seq("bresp_err", 0);

    setup(1'b1, -1, 0, 0, 1, 1);
    run_seq("timeout", 0);

    setup(1'b0, -1, 3, 0, 0, 0);
    run_seq("poll3_restart_ignored", 30);

    // reset while bias 10 is on the bus, then a clean full run
    setup(1'b0, -1, 1, 2, 2, 0);
    done_cnt = 0;
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
    cyc = 0;
    while (!(m_axil_awvalid && m_axil_awaddr == 7'd40) && cyc < 2000) begin
      @(negedge aclk); cyc++;
    end
    chk("reach_bias10", {31'd0, (cyc < 2000)}, 32'd1);
    #2 areset = 1'b1;
    @(negedge aclk);
    chk_reset_outputs("midreset");
    areset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge aclk);
    setup(1'b1, -1, 2, 1, 0, 0);
    run_seq("after_reset", 0);

    for (int r = 0; r < 3; r++) begin
      setup(1'b1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB)) : -1,
            int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      run_seq("random", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
